// File: rtl/energy_sample_scheduler_pkg.sv
// energy_sample_scheduler shared types and defaults.
// State encoding, parameter defaults and the channel-index type.
package energy_sched_pkg;

  localparam int NCH_DEF     = 4;
  localparam int PW_DEF      = 8;
  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 15;
  localparam int CW_DEF      = $clog2(NCH_DEF);

  typedef logic [CW_DEF-1:0] ch_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/energy_sample_scheduler_if.sv
// Collector handshake and sample output bundle.
// master = scheduler side, slave = collector / logging side.
interface energy_sample_scheduler_if
  import energy_sched_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          conv_start;
  logic [CW-1:0] conv_ch;
  logic          conv_done;
  logic [DW-1:0] conv_data;
  logic          smp_valid;
  logic [CW-1:0] smp_ch;
  logic [DW-1:0] smp_data;

  modport master (
    output conv_start, conv_ch,
    output smp_valid, smp_ch, smp_data,
    input  conv_done, conv_data
  );

  modport slave (
    input  conv_start, conv_ch,
    input  smp_valid, smp_ch, smp_data,
    output conv_done, conv_data
  );

endinterface

// File: rtl/energy_sample_scheduler_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr_i, wrapping.
// Purely combinational; one-hot grant plus encoded index.
module rr_arbiter #(
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [CW-1:0]  idx_o,
  output logic           any_o
);

  int            jj;
  logic [CW-1:0] j;

  // scan requests starting from the pointer
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    jj    = 0;
    j     = '0;
    for (int k = 0; k < NCH; k++) begin
      jj = (int'(ptr_i) + k) % NCH;
      j  = CW'(jj);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/energy_sample_scheduler.sv
// energy_sample_scheduler: per-channel period timers, round-robin grant,
// collector start/done handshake with timeout, one-cycle tagged samples.
module energy_sample_scheduler
  import energy_sched_pkg::*;
#(
  parameter  int NCH     = NCH_DEF,
  parameter  int PW      = PW_DEF,
  parameter  int DW      = DW_DEF,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int CW      = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [PW-1:0]  cfg_period,
  energy_sample_scheduler_if.master bus,
  output logic [NCH-1:0] overrun,
  output logic           timeout_err,
  output logic           busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   period_q [NCH];
  logic [PW-1:0]   cnt_q    [NCH];
  logic [NCH-1:0]  pend_q, ovr_q;
  logic [NCH-1:0]  expire, clr, gnt;
  logic [CW-1:0]   ptr_q, gidx, gch_q, smp_ch_q;
  logic [DW-1:0]   smp_data_q;
  logic [TW-1:0]   tcnt_q;
  logic            tout_q, any, grant, tmo;
  logic            start_s, valid_s;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req_i (pend_q),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (any)
  );

  assign grant = (state_q == IDLE) && ena && any;
  assign clr   = grant ? gnt : '0;
  assign tmo   = (tcnt_q == TW'(TIMEOUT - 1));

  // timer expiry: counter at period-1 while enabled and configured
  always_comb begin
    expire = '0;
    for (int i = 0; i < NCH; i++)
      expire[i] = ena && (period_q[i] != '0) &&
                  (cnt_q[i] == period_q[i] - PW'(1));
  end

  // per-channel period, counter, pending and sticky overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we && cfg_ch == CW'(i)) begin
          period_q[i] <= cfg_period;
          cnt_q[i]    <= '0;
          pend_q[i]   <= 1'b0;
        end else begin
          if (expire[i])
            cnt_q[i] <= '0;
          else if (ena && period_q[i] != '0)
            cnt_q[i] <= cnt_q[i] + PW'(1);
          if (expire[i]) begin
            pend_q[i] <= 1'b1;
            if (pend_q[i] && !clr[i])
              ovr_q[i] <= 1'b1;
          end else if (clr[i]) begin
            pend_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = START;
      START:   state_d = WAIT;
      WAIT: begin
        if (bus.conv_done) state_d = OUT;
        else if (tmo)      state_d = IDLE;
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from state
  always_comb begin
    start_s = (state_q == START);
    valid_s = (state_q == OUT);
    busy    = (state_q != IDLE);
  end

  // grant pointer, wait timer, captured sample and timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      gch_q      <= '0;
      tcnt_q     <= '0;
      smp_ch_q   <= '0;
      smp_data_q <= '0;
      tout_q     <= 1'b0;
    end else begin
      if (grant) begin
        gch_q <= gidx;
        ptr_q <= (gidx == CW'(NCH - 1)) ? '0 : gidx + CW'(1);
      end
      if (state_q == WAIT) tcnt_q <= tcnt_q + TW'(1);
      else                 tcnt_q <= '0;
      if (state_q == WAIT && bus.conv_done) begin
        smp_ch_q   <= gch_q;
        smp_data_q <= bus.conv_data;
      end
      if (state_q == WAIT && !bus.conv_done && tmo)
        tout_q <= 1'b1;
    end
  end

  assign bus.conv_start = start_s;
  assign bus.conv_ch    = gch_q;
  assign bus.smp_valid  = valid_s;
  assign bus.smp_ch     = smp_ch_q;
  assign bus.smp_data   = smp_data_q;
  assign overrun        = ovr_q;
  assign timeout_err    = tout_q;

endmodule
